// File: rtl/mux_b_pipe_pkg.sv
// Shared datapath constants for the ALU B-operand selector: select codes and their width.
package mips_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_REGB     = 3'b000;
  localparam logic [SEL_W-1:0] SEL_INC      = 3'b001;
  localparam logic [SEL_W-1:0] SEL_SEXT     = 3'b010;
  localparam logic [SEL_W-1:0] SEL_SEXT_SHL = 3'b011;
  localparam logic [SEL_W-1:0] SEL_ZEXT     = 3'b100;
  localparam logic [SEL_W-1:0] SEL_UPPER    = 3'b101;

  // Legal codes are contiguous from SEL_REGB up to SEL_UPPER.
  function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
    return (sel <= SEL_UPPER);
  endfunction

endpackage

// File: rtl/mux_b_pipe_if.sv
// Handshake bundle between the decoder/register-file side and the ALU B port.
interface mux_b_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int ERR_CNT_W = 8
);

  logic                       in_valid;
  logic                       in_ready;
  logic [mips_pkg::SEL_W-1:0] sel;
  logic [DATA_W-1:0]          reg_b_in;
  logic [IMM_W-1:0]           imm_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          operand_out;
  logic                       out_err;
  logic [ERR_CNT_W-1:0]       err_count;

  modport master (
    output in_valid, sel, reg_b_in, imm_in, out_ready,
    input  in_ready, out_valid, operand_out, out_err, err_count
  );

  modport slave (
    input  in_valid, sel, reg_b_in, imm_in, out_ready,
    output in_ready, out_valid, operand_out, out_err, err_count
  );

endinterface

// File: rtl/mux_b_pipe_skid_buf.sv
// Generic 2-entry valid/ready register slice; in_ready depends only on local state.
module skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_reg, main_valid_next;
  logic         skid_valid_reg, skid_valid_next;
  logic [W-1:0] main_data_reg, main_data_next;
  logic [W-1:0] skid_data_reg, skid_data_next;
  logic         accept;
  logic         consume;

  assign in_ready  = !skid_valid_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

  assign accept  = in_valid && !skid_valid_reg;
  assign consume = main_valid_reg && out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    main_data_next  = main_data_reg;
    skid_data_next  = skid_data_reg;
    if (skid_valid_reg) begin
      // Input is blocked while the skid entry is occupied; only a drain can happen.
      if (consume) begin
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end else if (!main_valid_reg || consume) begin
      main_valid_next = accept;
      if (accept) begin
        main_data_next = in_data;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      main_data_reg  <= main_data_next;
      skid_data_reg  <= skid_data_next;
    end
  end

endmodule

// File: rtl/mux_b_pipe.sv
// Registered ALU B-operand selector: forms the operand from sel/reg B/immediate and
// presents it through a skid slice, counting accepted illegal selects.
module mux_b_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int INC_CONST = 4,
  parameter int SHAMT     = 2,
  parameter int ERR_CNT_W = 8
) (
  input logic         clk,
  input logic         reset,
  mux_b_pipe_if.slave bus
);

  logic [DATA_W-1:0]    sext_w;
  logic [DATA_W-1:0]    zext_w;
  logic [DATA_W-1:0]    operand_next;
  logic                 err_next;
  logic                 in_ready_w;
  logic                 accept;
  logic [DATA_W:0]      out_data_w;
  logic [ERR_CNT_W-1:0] err_count_reg;

  always_comb begin
    sext_w       = DATA_W'($signed(bus.imm_in));
    zext_w       = DATA_W'(bus.imm_in);
    operand_next = '0;
    err_next     = !sel_is_legal(bus.sel);
    case (bus.sel)
      SEL_REGB:     operand_next = bus.reg_b_in;
      SEL_INC:      operand_next = DATA_W'(INC_CONST);
      SEL_SEXT:     operand_next = sext_w;
      SEL_SEXT_SHL: operand_next = sext_w << SHAMT;
      SEL_ZEXT:     operand_next = zext_w;
      // Immediate lands above IMM_W zero bits; anything past DATA_W-1 falls off.
      SEL_UPPER:    operand_next = zext_w << IMM_W;
      default:      operand_next = '0;
    endcase
  end

  skid_buf #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_ready (in_ready_w),
    .in_data  ({err_next, operand_next}),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (out_data_w)
  );

  assign bus.in_ready    = in_ready_w;
  assign bus.out_err     = out_data_w[DATA_W];
  assign bus.operand_out = out_data_w[DATA_W-1:0];
  assign bus.err_count   = err_count_reg;

  assign accept = bus.in_valid && in_ready_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_reg <= '0;
    end else if (accept && err_next && (err_count_reg != '1)) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_b_pipe.sv
// Bench for mux_b_pipe: directed literal checks plus a random run against a 2-deep FIFO model.
module tb_mux_b_pipe;
  import mips_pkg::*;

  localparam int DATA_W    = 32;
  localparam int IMM_W     = 16;
  localparam int ERR_CNT_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mux_b_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

  mux_b_pipe #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .INC_CONST(4), .SHAMT(2), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Operand rules written as plain arithmetic for the default 32/16 configuration.
  function automatic logic [32:0] ref_beat(input logic [2:0] s, input logic [31:0] rb,
                                           input logic [15:0] imm);
    logic [31:0] se;
    se = {{16{imm[15]}}, imm};
    case (s)
      3'd0:    return {1'b0, rb};
      3'd1:    return {1'b0, 32'd4};
      3'd2:    return {1'b0, se};
      3'd3:    return {1'b0, se * 32'd4};
      3'd4:    return {1'b0, 16'h0000, imm};
      3'd5:    return {1'b0, imm, 16'h0000};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Model: the block is a 2-entry FIFO; in_ready is "fewer than two held".
  logic [32:0] mq[$];
  int          model_errs = 0;
  int          accepted   = 0;

  always @(posedge clk or negedge reset) begin
    bit          pop_now;
    bit          push_now;
    logic [32:0] b;
    if (!reset) begin
      mq.delete();
      model_errs = 0;
    end else begin
      pop_now  = (mq.size() > 0) && (bus.out_ready === 1'b1);
      push_now = (bus.in_valid === 1'b1) && (mq.size() < 2);
      if (pop_now) void'(mq.pop_front());
      if (push_now) begin
        b = ref_beat(bus.sel, bus.reg_b_in, bus.imm_in);
        mq.push_back(b);
        accepted++;
        if (b[32] && model_errs < 255) model_errs++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("cmp_in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
      chk("cmp_err_count", 32'(bus.err_count), model_errs);
      if (mq.size() > 0) begin
        chk("cmp_operand", bus.operand_out, mq[0][31:0]);
        chk("cmp_out_err", 32'(bus.out_err), 32'(mq[0][32]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] rb,
                       input logic [15:0] imm);
    bus.in_valid = v;
    bus.sel      = s;
    bus.reg_b_in = rb;
    bus.imm_in   = imm;
  endtask

  logic [2:0]  t_sel[5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
  logic [31:0] t_exp[5] = '{32'hFFFF8001, 32'hFFFE0004, 32'h00008001, 32'h80010000, 32'h00000004};

  initial begin
    int start;
    int cyc;
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    bus.out_ready = 1'b0;

    repeat (2) step();
    cmp_en = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_operand", bus.operand_out, 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    #1 reset = 1'b1;

    drive(1'b1, 3'd0, 32'hDEADBEEF, 16'h0);
    bus.out_ready = 1'b1;
    step();
    chk("t1_operand", bus.operand_out, 32'hDEADBEEF);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_err", 32'(bus.out_err), 32'd0);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, t_sel[i], 32'h12345678, 16'h8001);
      step();
      chk($sformatf("t2_sel%0d_operand", t_sel[i]), bus.operand_out, t_exp[i]);
      chk($sformatf("t2_sel%0d_valid", t_sel[i]), 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    step();

    drive(1'b1, 3'd0, 32'h1111_1111, 16'h0);
    step();
    chk("t3_a_out", bus.operand_out, 32'h1111_1111);
    bus.reg_b_in  = 32'h2222_2222;
    bus.out_ready = 1'b0;
    step();
    chk("t3_a_held", bus.operand_out, 32'h1111_1111);
    chk("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.reg_b_in = 32'h3333_3333;
    step();
    chk("t3_a_still_held", bus.operand_out, 32'h1111_1111);
    chk("t3_c_blocked", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("t3_b_out", bus.operand_out, 32'h2222_2222);
    chk("t3_in_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    chk("t3_c_out", bus.operand_out, 32'h3333_3333);
    bus.in_valid = 1'b0;
    step();
    chk("t3_drained", 32'(bus.out_valid), 32'd0);

    drive(1'b1, 3'd6, 32'hFFFF_FFFF, 16'hFFFF);
    step();
    chk("t4_sel6_operand", bus.operand_out, 32'h0);
    chk("t4_sel6_err", 32'(bus.out_err), 32'd1);
    bus.sel = 3'd7;
    step();
    chk("t4_sel7_operand", bus.operand_out, 32'h0);
    chk("t4_sel7_err", 32'(bus.out_err), 32'd1);
    chk("t4_err_count_2", 32'(bus.err_count), 32'd2);
    for (int k = 0; k < 300; k++) begin
      bus.sel = (k % 2 == 0) ? 3'd6 : 3'd7;
      step();
    end
    bus.in_valid = 1'b0;
    chk("t4_err_count_sat", 32'(bus.err_count), 32'hFF);
    step();

    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h0000_0055, 16'h0);
    step();
    bus.reg_b_in = 32'h0000_0066;
    step();
    bus.in_valid = 1'b0;
    chk("t5_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_full_operand", bus.operand_out, 32'h0000_0055);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_rst_err_count", 32'(bus.err_count), 32'd0);
    chk("t5_rst_operand", bus.operand_out, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    drive(1'b1, 3'd0, 32'h0000_0077, 16'h0);
    bus.out_ready = 1'b1;
    step();
    chk("t5_first_operand", bus.operand_out, 32'h0000_0077);
    chk("t5_first_valid", 32'(bus.out_valid), 32'd1);

    start = accepted;
    cyc   = 0;
    while ((accepted - start) < 10000 && cyc < 60000) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
            16'($urandom_range(0, 65535)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    chk("t6_beats_accepted", accepted - start, 32'd10000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (bus.out_valid === 1'b1 && cyc < 5) begin
      step();
      cyc++;
    end
    chk("t6_drain", 32'(bus.out_valid), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
